wasca_trace_ctrl: RTL and testbench

WASCA_TRACE_CTRL -- requirements
Module: wasca_trace_ctrl

---
 rtl/wasca_trace_ctrl_pkg.sv | 20 ++
 rtl/wasca_trace_ctrl_if.sv | 35 +++
 rtl/wasca_trace_ctrl.sv | 133 +++++++++++++
 tb/tb_wasca_trace_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wasca_trace_ctrl_pkg.sv
// Shared definitions for the trace capture controller:
// capture states, CSR word addresses and CTRL bit positions.
package wasca_trace_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] CSR_CTRL = 2'd0;
   localparam logic [1:0] CSR_WPTR = 2'd1;
   localparam logic [1:0] CSR_TRIG = 2'd2;
   localparam logic [1:0] CSR_POST = 2'd3;

   localparam int CTRL_ARM   = 0;
   localparam int CTRL_ABORT = 1;

endpackage

// File: rtl/wasca_trace_ctrl_if.sv
// Host readback slave port plus external trace RAM master port.
// slave = controller side, master = host/RAM side.
interface wasca_trace_ctrl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 64
);
   logic [ADDR_W-1:0]   host_address;
   logic                host_read;
   logic                host_waitrequest;
   logic [DATA_W-1:0]   host_readdata;
   logic                host_readdatavalid;

   logic [ADDR_W-1:0]   mem_address;
   logic                mem_chipselect;
   logic                mem_write;
   logic [DATA_W/8-1:0] mem_byteenable;
   logic [DATA_W-1:0]   mem_writedata;
   logic [DATA_W-1:0]   mem_readdata;

   modport slave (
      input  host_address, host_read, mem_readdata,
      output host_waitrequest, host_readdata,
      output host_readdatavalid,
      output mem_address, mem_chipselect, mem_write,
      output mem_byteenable, mem_writedata
   );

   modport master (
      output host_address, host_read, mem_readdata,
      input  host_waitrequest, host_readdata,
      input  host_readdatavalid,
      input  mem_address, mem_chipselect, mem_write,
      input  mem_byteenable, mem_writedata
   );
endinterface

// File: rtl/wasca_trace_ctrl.sv
// Trace capture controller: writes trace entries into an external
// circular RAM around a trigger, with CSR control and host readback.
module wasca_trace_ctrl
   import wasca_trace_ctrl_pkg::*;
#(
   parameter int ADDR_W       = 9,
   parameter int DATA_W       = 64,
   parameter int POST_DEFAULT = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trace_valid,
   input  logic [DATA_W-1:0] trace_data,
   input  logic              trace_trig,
   input  logic [1:0]        csr_address,
   input  logic              csr_read,
   input  logic              csr_write,
   input  logic [31:0]       csr_writedata,
   output logic [31:0]       csr_readdata,
   wasca_trace_ctrl_if.slave bus
);

   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] CNT_RST = (ADDR_W+1)'(POST_DEFAULT);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] wptr, wptr_nx;
   logic [ADDR_W-1:0] trig_addr, trig_addr_nx;
   logic [ADDR_W:0]   remain, remain_nx;
   logic [ADDR_W:0]   post_cnt, post_cnt_nx;
   logic              wrapped, wrapped_nx;
   logic              triggered, triggered_nx;
   logic              rd_pend;
   logic              capture, accept;
   logic              ctrl_wr, arm, abort;
   logic              unused_wdata;

   assign unused_wdata = ^csr_writedata[31:ADDR_W+1];

   // Gating by reset keeps the RAM and host ports quiet in the reset cycle.
   assign capture = !reset && trace_valid &&
                    (state == ST_ARMED || state == ST_POST);
   assign accept  = !reset && bus.host_read && !capture;

   assign ctrl_wr = csr_write && (csr_address == CSR_CTRL);
   assign arm     = ctrl_wr && csr_writedata[CTRL_ARM];
   assign abort   = ctrl_wr && csr_writedata[CTRL_ABORT];

   always_comb begin
      state_nx     = state;
      wptr_nx      = wptr;
      trig_addr_nx = trig_addr;
      remain_nx    = remain;
      post_cnt_nx  = post_cnt;
      wrapped_nx   = wrapped;
      triggered_nx = triggered;
      if (capture) begin
         wptr_nx = wptr + 1'b1;
         if (&wptr)
            wrapped_nx = 1'b1;
         if (state == ST_ARMED && trace_trig) begin
            trig_addr_nx = wptr;
            triggered_nx = 1'b1;
            remain_nx    = post_cnt;
            state_nx     = (post_cnt == '0) ? ST_DONE : ST_POST;
         end else if (state == ST_POST) begin
            remain_nx = remain - CNT_ONE;
            if (remain == CNT_ONE)
               state_nx = ST_DONE;
         end
      end
      if (csr_write && csr_address == CSR_POST)
         post_cnt_nx = csr_writedata[ADDR_W:0];
      // Abort wins over arm; both override the capture bookkeeping.
      if (abort) begin
         state_nx = ST_IDLE;
      end else if (arm) begin
         wptr_nx      = '0;
         trig_addr_nx = '0;
         wrapped_nx   = 1'b0;
         triggered_nx = 1'b0;
         state_nx     = ST_ARMED;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         wptr      <= '0;
         trig_addr <= '0;
         remain    <= '0;
         post_cnt  <= CNT_RST;
         wrapped   <= 1'b0;
         triggered <= 1'b0;
      end else begin
         state     <= state_nx;
         wptr      <= wptr_nx;
         trig_addr <= trig_addr_nx;
         remain    <= remain_nx;
         post_cnt  <= post_cnt_nx;
         wrapped   <= wrapped_nx;
         triggered <= triggered_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend      <= 1'b0;
         csr_readdata <= '0;
      end else begin
         rd_pend <= accept;
         if (csr_read) begin
            unique case (csr_address)
               CSR_CTRL: csr_readdata <= {28'b0, wrapped, triggered, state};
               CSR_WPTR: csr_readdata <= 32'(wptr);
               CSR_TRIG: csr_readdata <= 32'(trig_addr);
               CSR_POST: csr_readdata <= 32'(post_cnt);
            endcase
         end
      end
   end

   assign bus.host_waitrequest   = bus.host_read && capture;
   assign bus.host_readdata      = bus.mem_readdata;
   assign bus.host_readdatavalid = rd_pend && !reset;

   assign bus.mem_chipselect = capture || accept;
   assign bus.mem_write      = capture;
   assign bus.mem_address    = capture ? wptr : bus.host_address;
   assign bus.mem_byteenable = capture ? '1 : '0;
   assign bus.mem_writedata  = trace_data;

endmodule

// File: tb/tb_wasca_trace_ctrl.sv
// Bench for wasca_trace_ctrl: table vectors, corner sequences and a
// random run against a behavioural model, with a RAM model attached.
module tb_wasca_trace_ctrl;
   import wasca_trace_ctrl_pkg::*;

   localparam int AW = 9;
   localparam int DW = 64;
   localparam int DEPTH = 512;
   localparam logic [DW-1:0] SENT = 64'hDEAD_BEEF_0BAD_F00D;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          trace_valid = 1'b0;
   logic          trace_trig = 1'b0;
   logic [DW-1:0] trace_data = '0;
   logic [1:0]    csr_address = '0;
   logic          csr_read = 1'b0;
   logic          csr_write = 1'b0;
   logic [31:0]   csr_writedata = '0;
   logic [31:0]   csr_readdata;

   wasca_trace_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   wasca_trace_ctrl #(.ADDR_W(AW), .DATA_W(DW), .POST_DEFAULT(256)) dut (
      .clk(clk),
      .reset(reset),
      .trace_valid(trace_valid),
      .trace_data(trace_data),
      .trace_trig(trace_trig),
      .csr_address(csr_address),
      .csr_read(csr_read),
      .csr_write(csr_write),
      .csr_writedata(csr_writedata),
      .csr_readdata(csr_readdata),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] ram [DEPTH];
   logic [DW-1:0] exp_ram [DEPTH];
   logic [DW-1:0] rdq = '0;
   logic          ram_clr = 1'b0;

   assign bus.mem_readdata = rdq;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= SENT;
      end else if (bus.mem_chipselect && bus.mem_write) begin
         ram[bus.mem_address] <= bus.mem_writedata;
      end
      if (bus.mem_chipselect && !bus.mem_write)
         rdq <= ram[bus.mem_address];
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      csr_address = a;
      csr_writedata = d;
      csr_write = 1'b1;
      step();
      csr_write = 1'b0;
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      csr_address = a;
      csr_read = 1'b1;
      step();
      csr_read = 1'b0;
      d = csr_readdata;
   endtask

   task automatic push(input logic [DW-1:0] d, input logic t);
      trace_valid = 1'b1;
      trace_data = d;
      trace_trig = t;
      step();
      trace_valid = 1'b0;
      trace_trig = 1'b0;
   endtask

   task automatic clear_ram();
      ram_clr = 1'b1;
      step();
      ram_clr = 1'b0;
   endtask

   function automatic logic [DW-1:0] vdata(input int v, input int i);
      return {32'hC0DE_0000 | 32'(v), 32'(i)};
   endfunction

   typedef struct {
      int post;
      int n;
      int trig_at;
      int st;
      int wp;
      int ta;
      int trg;
   } vec_t;

   vec_t vt [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      int m_st, m_wp, m_ta, m_wrap, m_trg, m_rem, m_post;
      bit cap, acc, ctrlw, rdv_exp, cp;
      logic [DW-1:0] rd_exp;
      logic [31:0] cp_exp;
      int r, k;

      vt[0] = '{256, 10, -1, 1, 10, 0, 0};
      vt[1] = '{4, 10, 2, 3, 7, 2, 1};
      vt[2] = '{0, 3, 0, 3, 1, 0, 1};
      vt[3] = '{5, 4, 1, 2, 4, 1, 1};
      vt[4] = '{1, 5, 3, 3, 5, 3, 1};

      bus.host_read = 1'b0;
      bus.host_address = '0;

      // reset state
      step();
      step();
      chk("rst_rdv", 64'(bus.host_readdatavalid), 64'(0));
      chk("rst_wait", 64'(bus.host_waitrequest), 64'(0));
      chk("rst_cs", 64'(bus.mem_chipselect), 64'(0));
      chk("rst_we", 64'(bus.mem_write), 64'(0));
      chk("rst_csr", 64'(csr_readdata), 64'(0));
      reset = 1'b0;
      csr_rd(CSR_CTRL, d); chk("rst_status", 64'(d), 64'(0));
      csr_rd(CSR_WPTR, d); chk("rst_wptr", 64'(d), 64'(0));
      csr_rd(CSR_TRIG, d); chk("rst_trig", 64'(d), 64'(0));
      csr_rd(CSR_POST, d); chk("rst_post", 64'(d), 64'(256));

      // table vectors
      for (int v = 0; v < 5; v++) begin
         clear_ram();
         csr_wr(CSR_POST, 32'(vt[v].post));
         csr_wr(CSR_CTRL, 32'd1);
         for (int i = 0; i < vt[v].n; i++)
            push(vdata(v, i), i == vt[v].trig_at);
         csr_rd(CSR_CTRL, d);
         chk("vec_status", 64'(d), 64'(vt[v].trg * 4 + vt[v].st));
         csr_rd(CSR_WPTR, d);
         chk("vec_wptr", 64'(d), 64'(vt[v].wp));
         csr_rd(CSR_TRIG, d);
         chk("vec_trig", 64'(d), 64'(vt[v].ta));
         csr_rd(CSR_POST, d);
         chk("vec_post", 64'(d), 64'(vt[v].post));
         for (int i = 0; i < vt[v].n; i++)
            chk("vec_ram", ram[i], (i < vt[v].wp) ? vdata(v, i) : SENT);
      end

      // arm+abort in one write from DONE; wptr kept, capture ignored
      csr_wr(CSR_CTRL, 32'd3);
      csr_rd(CSR_CTRL, d); chk("abort_status", 64'(d), 64'(4));
      csr_rd(CSR_WPTR, d); chk("abort_wptr", 64'(d), 64'(5));
      trace_valid = 1'b1;
      #1;
      chk("idle_cs", 64'(bus.mem_chipselect), 64'(0));
      step();
      trace_valid = 1'b0;
      csr_wr(CSR_WPTR, 32'd77);
      csr_wr(CSR_TRIG, 32'd88);
      csr_rd(CSR_WPTR, d); chk("ro_wptr", 64'(d), 64'(5));
      csr_rd(CSR_TRIG, d); chk("ro_trig", 64'(d), 64'(3));

      // wrap-around
      clear_ram();
      csr_wr(CSR_CTRL, 32'd1);
      for (int i = 0; i < 515; i++) push(64'(i), 1'b0);
      csr_rd(CSR_CTRL, d); chk("wrap_status", 64'(d), 64'(9));
      csr_rd(CSR_WPTR, d); chk("wrap_wptr", 64'(d), 64'(3));
      for (int i = 0; i < 3; i++) chk("wrap_ram", ram[i], 64'(512 + i));
      chk("wrap_ram3", ram[3], 64'(3));
      chk("wrap_ram511", ram[511], 64'(511));

      // host read colliding with a capture write
      trace_valid = 1'b1;
      trace_data = 64'h1234_5678_9ABC_DEF0;
      bus.host_read = 1'b1;
      bus.host_address = 9'd5;
      #1;
      chk("col_wait", 64'(bus.host_waitrequest), 64'(1));
      chk("col_addr", 64'(bus.mem_address), 64'(3));
      chk("col_we", 64'(bus.mem_write), 64'(1));
      chk("col_be", 64'(bus.mem_byteenable), 64'hFF);
      step();
      trace_valid = 1'b0;
      #1;
      chk("acc_wait", 64'(bus.host_waitrequest), 64'(0));
      chk("acc_cs", 64'(bus.mem_chipselect), 64'(1));
      chk("acc_we", 64'(bus.mem_write), 64'(0));
      chk("acc_addr", 64'(bus.mem_address), 64'(5));
      chk("acc_rdv", 64'(bus.host_readdatavalid), 64'(0));
      step();
      bus.host_read = 1'b0;
      chk("rd_rdv", 64'(bus.host_readdatavalid), 64'(1));
      chk("rd_data", bus.host_readdata, 64'(5));
      chk("col_ram", ram[3], 64'h1234_5678_9ABC_DEF0);
      step();
      chk("rd_rdv_off", 64'(bus.host_readdatavalid), 64'(0));

      // post_cnt change during POST applies to the next trigger only
      csr_wr(CSR_POST, 32'd2);
      csr_wr(CSR_CTRL, 32'd1);
      push(64'd1, 1'b1);
      csr_wr(CSR_POST, 32'd6);
      push(64'd2, 1'b0);
      push(64'd3, 1'b0);
      csr_rd(CSR_CTRL, d); chk("pchg_status", 64'(d), 64'(7));
      csr_rd(CSR_WPTR, d); chk("pchg_wptr", 64'(d), 64'(3));
      csr_rd(CSR_POST, d); chk("pchg_post", 64'(d), 64'(6));

      // reset in POST with a read in flight
      clear_ram();
      csr_wr(CSR_POST, 32'd8);
      csr_wr(CSR_CTRL, 32'd1);
      push(64'd42, 1'b1);
      bus.host_read = 1'b1;
      bus.host_address = 9'd0;
      step();
      bus.host_read = 1'b0;
      reset = 1'b1;
      trace_valid = 1'b1;
      trace_data = 64'd99;
      #1;
      chk("rpost_cs", 64'(bus.mem_chipselect), 64'(0));
      chk("rpost_we", 64'(bus.mem_write), 64'(0));
      chk("rpost_rdv", 64'(bus.host_readdatavalid), 64'(0));
      step();
      reset = 1'b0;
      trace_valid = 1'b0;
      chk("rpost_rdv2", 64'(bus.host_readdatavalid), 64'(0));
      chk("rpost_ram", ram[1], SENT);
      csr_rd(CSR_CTRL, d); chk("rpost_status", 64'(d), 64'(0));
      csr_rd(CSR_POST, d); chk("rpost_post", 64'(d), 64'(256));
      csr_rd(CSR_WPTR, d); chk("rpost_wptr", 64'(d), 64'(0));

      // random run against the reference model
      reset = 1'b1;
      step();
      reset = 1'b0;
      exp_ram = ram;
      m_st = 0; m_wp = 0; m_ta = 0; m_wrap = 0; m_trg = 0;
      m_rem = 0; m_post = 256;
      for (int c = 0; c < 4000; c++) begin
         csr_write = 1'b0;
         csr_read = 1'b0;
         r = int'($urandom_range(0, 999));
         if (r < 15) begin
            csr_write = 1'b1;
            csr_address = CSR_CTRL;
            k = int'($urandom_range(0, 5));
            csr_writedata = (k < 4) ? 32'd1 : ((k == 4) ? 32'd2 : 32'd3);
         end else if (r < 25) begin
            csr_write = 1'b1;
            csr_address = CSR_POST;
            csr_writedata = $urandom_range(0, 20);
         end else if (r < 30) begin
            csr_write = 1'b1;
            csr_address = 2'($urandom_range(1, 2));
            csr_writedata = $urandom;
         end else if (r < 90) begin
            csr_read = 1'b1;
            csr_address = 2'($urandom_range(0, 3));
         end
         ctrlw = csr_write && csr_address == CSR_CTRL;
         trace_valid = !ctrlw && ($urandom_range(0, 9) < 7);
         trace_trig = ($urandom_range(0, 24) == 0);
         trace_data = {$urandom, $urandom};
         bus.host_read = ($urandom_range(0, 3) == 0);
         bus.host_address = 9'($urandom_range(0, DEPTH - 1));
         #1;
         cap = trace_valid && (m_st == 1 || m_st == 2);
         acc = bus.host_read && !cap;
         chk("rnd_wait", 64'(bus.host_waitrequest), 64'(bus.host_read && cap));
         chk("rnd_cs", 64'(bus.mem_chipselect), 64'(cap || bus.host_read));
         chk("rnd_we", 64'(bus.mem_write), 64'(cap));
         if (cap)
            chk("rnd_waddr", 64'(bus.mem_address), 64'(m_wp));
         else if (acc)
            chk("rnd_raddr", 64'(bus.mem_address), 64'(bus.host_address));
         cp = csr_read;
         case (csr_address)
            CSR_CTRL: cp_exp = 32'(m_wrap * 8 + m_trg * 4 + m_st);
            CSR_WPTR: cp_exp = 32'(m_wp);
            CSR_TRIG: cp_exp = 32'(m_ta);
            default:  cp_exp = 32'(m_post);
         endcase
         rdv_exp = acc;
         rd_exp = exp_ram[bus.host_address];
         @(posedge clk);
         if (cap) begin
            exp_ram[m_wp] = trace_data;
            if (m_wp == DEPTH - 1) m_wrap = 1;
            if (m_st == 1 && trace_trig) begin
               m_ta = m_wp;
               m_trg = 1;
               m_rem = m_post;
               m_st = (m_post == 0) ? 3 : 2;
            end else if (m_st == 2) begin
               m_rem = m_rem - 1;
               if (m_rem == 0) m_st = 3;
            end
            m_wp = (m_wp + 1) % DEPTH;
         end
         if (ctrlw && csr_writedata[1]) begin
            m_st = 0;
         end else if (ctrlw && csr_writedata[0]) begin
            m_st = 1; m_wp = 0; m_ta = 0; m_wrap = 0; m_trg = 0;
         end
         if (csr_write && csr_address == CSR_POST)
            m_post = int'(csr_writedata % 1024);
         #1;
         chk("rnd_rdv", 64'(bus.host_readdatavalid), 64'(rdv_exp));
         if (rdv_exp)
            chk("rnd_rdata", bus.host_readdata, rd_exp);
         if (cp)
            chk("rnd_csr", 64'(csr_readdata), 64'(cp_exp));
      end
      trace_valid = 1'b0;
      trace_trig = 1'b0;
      bus.host_read = 1'b0;
      csr_write = 1'b0;
      csr_read = 1'b0;
      step();
      for (int i = 0; i < DEPTH; i++)
         chk("rnd_ram", ram[i], exp_ram[i]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
